// File: rtl/ofdm_rx_sample_pacer.sv
// Paces buffered I/Q samples into the OFDM RX path at a programmable strobe period.
// Empty-FIFO strobes are reported as underflow pulses and counted (saturating).
module ofdm_rx_sample_pacer #(
    parameter int sample_bit_width_g = 12,
    parameter int fifo_depth_g       = 16,
    parameter int period_width_g     = 8,
    parameter int default_period_g   = 24
) (
    input  logic                                sys_clk,
    input  logic                                sys_rstn,
    input  logic                                sys_init,
    input  logic                                enable,
    input  logic [period_width_g-1:0]           period,
    input  logic [sample_bit_width_g-1:0]       in_i,
    input  logic [sample_bit_width_g-1:0]       in_q,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [sample_bit_width_g-1:0]       rx_data_i,
    output logic [sample_bit_width_g-1:0]       rx_data_q,
    output logic                                rx_data_valid,
    output logic [$clog2(fifo_depth_g):0]       fifo_level,
    output logic                                underflow,
    output logic [15:0]                         underflow_cnt
);

    localparam int AW = $clog2(fifo_depth_g);
    localparam int SW = sample_bit_width_g;
    localparam int PW = period_width_g;

    logic [SW-1:0] r_mem_i [fifo_depth_g];
    logic [SW-1:0] r_mem_q [fifo_depth_g];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] r_period;
    logic [SW-1:0] r_rx_data_i;
    logic [SW-1:0] r_rx_data_q;
    logic          r_rx_data_valid;
    logic          r_underflow;
    logic [15:0]   r_underflow_cnt;

    logic [AW:0]   w_level;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_last_cnt;
    logic          w_strobe;
    logic          w_wr;
    logic          w_pop;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == (AW+1)'(fifo_depth_g));
    assign w_empty = (w_level == '0);

    // Periods of 0 and 1 both collapse to a strobe on every enabled cycle.
    assign w_last_cnt = (r_period <= PW'(1)) ? '0 : (r_period - PW'(1));
    assign w_strobe   = enable && (r_cnt == w_last_cnt);

    // Emptiness is judged on the registered level, so a same-cycle write never falls through.
    assign w_wr  = in_valid && !w_full;
    assign w_pop = w_strobe && !w_empty;

    assign in_ready      = !w_full;
    assign fifo_level    = w_level;
    assign rx_data_i     = r_rx_data_i;
    assign rx_data_q     = r_rx_data_q;
    assign rx_data_valid = r_rx_data_valid;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

    always_ff @(posedge sys_clk) begin
        if (w_wr && !sys_init) begin
            r_mem_i[r_wr_ptr[AW-1:0]] <= in_i;
            r_mem_q[r_wr_ptr[AW-1:0]] <= in_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cnt           <= '0;
            r_period        <= PW'(default_period_g);
            r_rx_data_i     <= '0;
            r_rx_data_q     <= '0;
            r_rx_data_valid <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else if (sys_init) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cnt           <= '0;
            r_period        <= PW'(default_period_g);
            r_rx_data_i     <= '0;
            r_rx_data_q     <= '0;
            r_rx_data_valid <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            if (!enable || w_strobe) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end

            // New period only takes hold at an interval boundary or while idle.
            if (!enable || w_strobe) begin
                r_period <= period;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end

            r_rx_data_valid <= w_pop;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + (AW+1)'(1);
                r_rx_data_i <= r_mem_i[r_rd_ptr[AW-1:0]];
                r_rx_data_q <= r_mem_q[r_rd_ptr[AW-1:0]];
            end

            r_underflow <= w_strobe && w_empty;
            if (w_strobe && w_empty && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_rx_sample_pacer.sv
// Directed bench for ofdm_rx_sample_pacer: pacing, underflow, backpressure,
// period changes, init/reset clearing and underflow counter saturation.
module tb_ofdm_rx_sample_pacer;

    localparam int SW = 12;
    localparam int PW = 8;
    localparam int LW = 5;

    logic          sys_clk;
    logic          sys_rstn;
    logic          sys_init;
    logic          enable;
    logic [PW-1:0] period;
    logic [SW-1:0] in_i;
    logic [SW-1:0] in_q;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] rx_data_i;
    logic [SW-1:0] rx_data_q;
    logic          rx_data_valid;
    logic [LW-1:0] fifo_level;
    logic          underflow;
    logic [15:0]   underflow_cnt;

    int checks;
    int failures;

    ofdm_rx_sample_pacer #(
        .sample_bit_width_g (SW),
        .fifo_depth_g       (16),
        .period_width_g     (PW),
        .default_period_g   (24)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .sys_init      (sys_init),
        .enable        (enable),
        .period        (period),
        .in_i          (in_i),
        .in_q          (in_q),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rx_data_i     (rx_data_i),
        .rx_data_q     (rx_data_q),
        .rx_data_valid (rx_data_valid),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until rx_data_valid (or underflow if want_uf) is seen; n = ticks taken, or max on timeout.
    task automatic wait_pulse(input int max, input bit want_uf, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((want_uf ? underflow : rx_data_valid) !== 1'b1) && (n < max));
    endtask

    task automatic push(input int vi, input int vq);
        in_i     = SW'(vi);
        in_q     = SW'(vq);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    int            n;
    int            k;
    int            vcnt;
    int            ucnt;
    bit            accepted;
    logic [SW-1:0] e_q;

    initial begin
        checks   = 0;
        failures = 0;
        sys_rstn = 1'b0;
        sys_init = 1'b0;
        enable   = 1'b0;
        period   = 8'd24;
        in_i     = '0;
        in_q     = '0;
        in_valid = 1'b0;
        tick();
        tick();

        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_valid", rx_data_valid, 0);
        check("rst_uf", underflow, 0);
        check("rst_ufcnt", underflow_cnt, 0);
        check("rst_data_i", rx_data_i, 0);
        sys_rstn = 1'b1;
        tick();

        // Default pacing: 4 samples at the reset period of 24
        for (int i = 1; i <= 4; i++) push(i, -i);
        check("t1_level4", fifo_level, 4);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_pulse(40, 1'b0, n);
            e_q = SW'(-i);
            check("t1_interval", n, 24);
            check("t1_data_i", rx_data_i, i);
            check("t1_data_q", rx_data_q, e_q);
            check("t1_level", fifo_level, 4 - i);
        end
        enable = 1'b0;
        check("t1_ufcnt", underflow_cnt, 0);

        // Underflow on an empty FIFO with period 5
        sys_init = 1'b1;
        tick();
        sys_init = 1'b0;
        period   = 8'd5;
        tick();
        enable = 1'b1;
        vcnt = 0;
        ucnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_data_valid) vcnt++;
            if (underflow) ucnt++;
        end
        enable = 1'b0;
        check("t2_uf_pulses", ucnt, 4);
        check("t2_valid_pulses", vcnt, 0);
        check("t2_ufcnt", underflow_cnt, 4);
        check("t2_data_i", rx_data_i, 0);
        check("t2_data_q", rx_data_q, 0);

        // Fill to full with backpressure, then drain at period 2
        k = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_i     = SW'(k);
            in_q     = SW'(-k);
            accepted = in_ready;
            tick();
            if (accepted) k++;
        end
        in_valid = 1'b0;
        check("t3_writes", k, 16);
        check("t3_ready", in_ready, 0);
        check("t3_level", fifo_level, 16);
        period = 8'd2;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_pulse(10, 1'b0, n);
            check("t3_interval", n, 2);
            check("t3_data_i", rx_data_i, i);
        end
        enable = 1'b0;
        check("t3_level_end", fifo_level, 0);
        check("t3_ready_end", in_ready, 1);

        // Mid-interval period change, then period 0
        period = 8'd10;
        for (int i = 0; i < 6; i++) push(100 + i, 0);
        enable = 1'b1;
        repeat (3) tick();
        period = 8'd4;
        wait_pulse(20, 1'b0, n);
        check("t4_first", n, 7);
        check("t4_d0", rx_data_i, 100);
        wait_pulse(20, 1'b0, n);
        check("t4_p4a", n, 4);
        check("t4_d1", rx_data_i, 101);
        wait_pulse(20, 1'b0, n);
        check("t4_p4b", n, 4);
        check("t4_d2", rx_data_i, 102);
        period = 8'd0;
        wait_pulse(20, 1'b0, n);
        check("t4_p4c", n, 4);
        check("t4_d3", rx_data_i, 103);
        wait_pulse(20, 1'b0, n);
        check("t4_p0a", n, 1);
        check("t4_d4", rx_data_i, 104);
        wait_pulse(20, 1'b0, n);
        check("t4_p0b", n, 1);
        check("t4_d5", rx_data_i, 105);
        check("t4_level", fifo_level, 0);
        tick();
        check("t4_no_valid", rx_data_valid, 0);
        check("t4_uf", underflow, 1);
        enable = 1'b0;

        // Synchronous init mid-operation
        sys_init = 1'b1;
        tick();
        sys_init = 1'b0;
        period   = 8'd1;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(200 + i, i);
        check("t5_level8", fifo_level, 8);
        check("t5_ufcnt3", underflow_cnt, 3);
        sys_init = 1'b1;
        in_valid = 1'b1;
        enable   = 1'b1;
        period   = 8'd3;
        tick();
        sys_init = 1'b0;
        in_valid = 1'b0;
        check("t5_init_level", fifo_level, 0);
        check("t5_init_ufcnt", underflow_cnt, 0);
        check("t5_init_valid", rx_data_valid, 0);
        check("t5_init_uf", underflow, 0);
        wait_pulse(40, 1'b1, n);
        check("t5_default_period", n, 24);
        check("t5_no_valid", rx_data_valid, 0);
        enable = 1'b0;

        // Asynchronous reset mid-cycle
        period = 8'd2;
        push(300, 1);
        push(301, 2);
        enable = 1'b1;
        wait_pulse(10, 1'b0, n);
        check("t5_pre_rst_data", rx_data_i, 300);
        #2;
        sys_rstn = 1'b0;
        #1;
        check("t5_rst_valid", rx_data_valid, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_data", rx_data_i, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_ufcnt", underflow_cnt, 0);
        enable = 1'b0;
        tick();
        sys_rstn = 1'b1;
        tick();

        // Underflow counter saturation at period 1
        period = 8'd1;
        tick();
        enable = 1'b1;
        repeat (65534) tick();
        check("t6_ufcnt_fffe", underflow_cnt, 16'hFFFE);
        tick();
        check("t6_ufcnt_ffff", underflow_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_uf_pulse", underflow, 1);
            check("t6_ufcnt_sat", underflow_cnt, 16'hFFFF);
        end
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofdm_rx_sample_pacer.md
Name: ofdm_rx_sample_pacer

Overview:
Paces complex baseband samples into the OFDM RX path at a runtime-programmable rate. It generalises the fixed 24-clock RX data strobe to a configurable period and adds buffering. A ready/valid source (sample loader, ADC capture, DMA) fills an internal I/Q FIFO. The block emits one sample per strobe as a single-cycle rx_data_valid pulse and counts strobes that find no data (underflows). It sits directly in front of the OFDM RX top level and drives its rx_data_i/rx_data_q/rx_data_valid inputs.

Parameters:
sample_bit_width_g, 12, width of each I and Q sample (signed, two's complement)
fifo_depth_g, 16, FIFO depth in samples; power of two, at least 2
period_width_g, 8, width of the period input
default_period_g, 24, period loaded at reset and on sys_init

Ports:
sys_clk  in  1  system clock, all logic rising-edge
sys_rstn  in  1  asynchronous active-low reset
sys_init  in  1  synchronous clear pulse; highest priority after reset
enable  in  1  1 = strobe generator runs; 0 = counter held at 0, no strobes
period  in  period_width_g  strobe period in clocks; sampled only at load points
in_i  in  sample_bit_width_g  source I sample
in_q  in  sample_bit_width_g  source Q sample
in_valid  in  1  source sample valid
in_ready  out  1  FIFO not full
rx_data_i  out  sample_bit_width_g  paced I sample to RX
rx_data_q  out  sample_bit_width_g  paced Q sample to RX
rx_data_valid  out  1  one-cycle pulse per emitted sample
fifo_level  out  clog2(fifo_depth_g)+1  current FIFO occupancy
underflow  out  1  one-cycle pulse when a strobe finds the FIFO empty
underflow_cnt  out  16  saturating underflow count

Behaviour:
- Reset (async, sys_rstn=0):
  - FIFO empty, fifo_level=0, in_ready=1 (combinational from not-full).
  - rx_data_i/q=0, rx_data_valid=0, underflow=0, underflow_cnt=0.
  - Strobe counter=0, active period register=default_period_g.
- sys_init=1: same clear as reset, synchronous, applied in that cycle. Any write or strobe in that cycle is discarded.
- Period register load points: every cycle enable=0, and the cycle a strobe fires. A mid-interval change of period takes effect from the next interval. Loaded values 0 or 1 mean a strobe every enabled cycle.
- Strobe counter:
  - While enable=1, increments each cycle.
  - When cnt == period_reg-1, the internal strobe fires that cycle and cnt returns to 0.
  - First strobe comes on the period_reg-th enabled cycle after enable rises.
  - enable=0 forces cnt=0 immediately, so a partial interval is lost.
- FIFO write: a write occurs when in_valid && in_ready. Data lands at the write pointer. Pointers wrap modulo fifo_depth_g.
- FIFO read on strobe:
  - FIFO non-empty: pop the head. rx_data_i/q are registered with it and rx_data_valid=1 in the next cycle, so latency is strobe cycle + 1.
  - FIFO empty: no pop, rx_data_valid stays 0, rx_data_i/q hold their previous values, underflow=1 next cycle.
  - underflow_cnt increments on each underflow and saturates at 0xFFFF.
- No fall-through: a sample written in the same cycle as a strobe on an empty FIFO is not emitted. That strobe counts as an underflow and the sample stays queued.
- Simultaneous write and pop on a non-empty, non-full FIFO: fifo_level unchanged.
- Full FIFO: in_ready=0 and the write is refused. A pop in the same cycle frees space only from the next cycle, since in_ready does not depend on the pop.
- rx_data_valid is never high on two consecutive cycles unless period_reg<=1.
- rx_data_i/q are only meaningful when rx_data_valid=1.

Test Plan:
- Default pacing: after reset, push 4 samples (I=1..4, Q=-1..-4), enable=1 → rx_data_valid pulses on enabled cycles 25, 49, 73, 97 with I=1,2,3,4 and Q=-1..-4 in order; fifo_level 4→0; underflow_cnt=0.
- Underflow: empty FIFO, period=5, enable for 20 cycles → 4 underflow pulses, no rx_data_valid, underflow_cnt=4, rx_data_i/q remain 0.
- Full/backpressure: enable=0, in_valid held high with incrementing data → in_ready drops after 16 writes, fifo_level=16. Set enable=1, period=2 → samples 0..15 emitted in order, none lost or duplicated.
- Period change mid-interval: period=10; at cnt=3 set period=4 → next strobe still at cnt 9, following strobes every 4 cycles; period=0 → rx_data_valid every cycle while the FIFO is non-empty.
- Init/reset mid-operation: FIFO holds 8 samples and underflow_cnt=3; pulse sys_init → next cycle fifo_level=0, underflow_cnt=0, cnt=0, period_reg=24, no rx_data_valid. Repeat with async sys_rstn low mid-cycle → outputs clear immediately.
- Saturation: force 65540 underflows with period=1 → underflow_cnt stops at 0xFFFF while underflow pulses continue.
